// File: rtl/hazard_pkg.sv
// hazard_pkg: shared types for the ID/EX hazard and forwarding controller.
// Holds the scoreboard entry layout and the forward-select width helper.
package hazard_pkg;

    // Scoreboard rd field is sized for the widest supported register index.
    // Narrower indices are zero-extended on entry and on compare.
    localparam int SB_RD_W = 8;

    // Forward select value meaning "read the register file".
    localparam int FWD_REGFILE = 0;

    typedef struct packed {
        logic               valid;
        logic [SB_RD_W-1:0] rd;
        logic               regwrite;
        logic               memread;
    } sb_entry_t;

    // Width of a select that encodes 0 (regfile) plus entries 1..n_fwd.
    function automatic int fsel_w(input int n_fwd);
        return $clog2(n_fwd + 1);
    endfunction

endpackage

// File: rtl/hazard_match.sv
// hazard_match: compares one source register against every scoreboard entry.
// Returns the index of the youngest matching producer, or FWD_REGFILE.
module hazard_match
    import hazard_pkg::*;
#(
    parameter int REG_W    = 5,
    parameter int N_FWD    = 2,
    parameter int ZERO_REG = 31,
    parameter int FSEL_W   = 2
) (
    input  sb_entry_t [N_FWD:1] sb_i,
    input  logic [REG_W-1:0]    src_i,
    input  logic                use_i,
    output logic [FSEL_W-1:0]   sel_o
);

    logic src_ok;
    logic unused_memread;

    // XZR and unread sources never match anything.
    assign src_ok = use_i && (src_i != REG_W'(ZERO_REG));

    // Scan oldest to youngest so the youngest matching producer wins.
    always_comb begin
        sel_o = FSEL_W'(FWD_REGFILE);
        for (int k = N_FWD; k >= 1; k--) begin
            if (src_ok && sb_i[k].valid && sb_i[k].regwrite &&
                (sb_i[k].rd == SB_RD_W'(src_i))) begin
                sel_o = FSEL_W'(k);
            end
        end
    end

    // Load flags matter only to the stall logic, not to forwarding.
    always_comb begin
        unused_memread = 1'b0;
        for (int k = 1; k <= N_FWD; k++) begin
            unused_memread = unused_memread ^ sb_i[k].memread;
        end
    end

endmodule

// File: rtl/hazard_unit.sv
// hazard_unit: scoreboard-based forwarding, load-use stall and branch flush.
// Optional HAZARD_PERF_EN adds saturating stall_cnt/flush_cnt outputs.
module hazard_unit
    import hazard_pkg::*;
#(
    parameter int  REG_W    = 5,
    parameter int  N_FWD    = 2,
    parameter int  BR_STAGE = 2,
    parameter int  ZERO_REG = 31,
    localparam int FSEL_W   = fsel_w(N_FWD)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              id_valid,
    input  logic [REG_W-1:0]  id_rn,
    input  logic [REG_W-1:0]  id_rm,
    input  logic              id_use_rn,
    input  logic              id_use_rm,
    input  logic [REG_W-1:0]  id_rd,
    input  logic              id_regwrite,
    input  logic              id_memread,
    input  logic              br_taken,
    output logic [FSEL_W-1:0] fwd_a,
    output logic [FSEL_W-1:0] fwd_b,
    output logic              stall,
    output logic              flush
`ifdef HAZARD_PERF_EN
    ,
    output logic [31:0]       stall_cnt,
    output logic [31:0]       flush_cnt
`endif
);

    sb_entry_t [N_FWD:1] sb_q;
    sb_entry_t [N_FWD:1] sb_d;
    logic [FSEL_W-1:0]   sel_a;
    logic [FSEL_W-1:0]   sel_b;
    logic                load_use;
    logic                issue;

    hazard_match #(
        .REG_W    (REG_W),
        .N_FWD    (N_FWD),
        .ZERO_REG (ZERO_REG),
        .FSEL_W   (FSEL_W)
    ) u_match_rn (
        .sb_i  (sb_q),
        .src_i (id_rn),
        .use_i (id_use_rn),
        .sel_o (sel_a)
    );

    hazard_match #(
        .REG_W    (REG_W),
        .N_FWD    (N_FWD),
        .ZERO_REG (ZERO_REG),
        .FSEL_W   (FSEL_W)
    ) u_match_rm (
        .sb_i  (sb_q),
        .src_i (id_rm),
        .use_i (id_use_rm),
        .sel_o (sel_b)
    );

    // Entry 1 matching either source is exactly a youngest-match of 1.
    assign load_use = id_valid && sb_q[1].valid && sb_q[1].memread &&
                      ((sel_a == FSEL_W'(1)) || (sel_b == FSEL_W'(1)));

    // A squashed branch leaves valid low, so its br_taken is ignored.
    assign flush = br_taken && sb_q[BR_STAGE].valid && !reset;
    assign stall = load_use && !flush && !reset;
    assign fwd_a = reset ? '0 : sel_a;
    assign fwd_b = reset ? '0 : sel_b;
    assign issue = id_valid && !stall && !flush;

    // Age every entry by one, admit ID or a bubble, then squash on flush.
    always_comb begin
        sb_d = '0;
        for (int k = 2; k <= N_FWD; k++) begin
            sb_d[k] = sb_q[k-1];
        end
        if (issue) begin
            sb_d[1] = '{valid:    1'b1,
                        rd:       SB_RD_W'(id_rd),
                        regwrite: id_regwrite,
                        memread:  id_memread};
        end
        if (flush) begin
            for (int k = 1; k <= BR_STAGE; k++) begin
                sb_d[k].valid = 1'b0;
            end
        end
    end

    // Scoreboard register; reset empties every entry.
    always_ff @(posedge clk) begin
        if (reset) begin
            sb_q <= '0;
        end else begin
            sb_q <= sb_d;
        end
    end

`ifdef HAZARD_PERF_EN
    logic [31:0] stall_cnt_q;
    logic [31:0] flush_cnt_q;

    // Saturating counts of stall and flush cycles.
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (stall && (stall_cnt_q != 32'hFFFF_FFFF)) begin
                stall_cnt_q <= stall_cnt_q + 32'd1;
            end
            if (flush && (flush_cnt_q != 32'hFFFF_FFFF)) begin
                flush_cnt_q <= flush_cnt_q + 32'd1;
            end
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_unit.sv
// tb_hazard_unit: table-driven cycle vectors for hazard_unit.
// Expected outputs are queued at drive time and checked mid-cycle.
module tb_hazard_unit;

    logic       clk = 1'b0;
    logic       reset;
    logic       id_valid;
    logic [4:0] id_rn;
    logic [4:0] id_rm;
    logic       id_use_rn;
    logic       id_use_rm;
    logic [4:0] id_rd;
    logic       id_regwrite;
    logic       id_memread;
    logic       br_taken;
    logic [1:0] fwd_a;
    logic [1:0] fwd_b;
    logic       stall;
    logic       flush;
`ifdef HAZARD_PERF_EN
    logic [31:0] stall_cnt;
    logic [31:0] flush_cnt;
`endif

    always #5 clk = ~clk;

    hazard_unit dut (
        .clk         (clk),
        .reset       (reset),
        .id_valid    (id_valid),
        .id_rn       (id_rn),
        .id_rm       (id_rm),
        .id_use_rn   (id_use_rn),
        .id_use_rm   (id_use_rm),
        .id_rd       (id_rd),
        .id_regwrite (id_regwrite),
        .id_memread  (id_memread),
        .br_taken    (br_taken),
        .fwd_a       (fwd_a),
        .fwd_b       (fwd_b),
        .stall       (stall),
        .flush       (flush)
`ifdef HAZARD_PERF_EN
        ,
        .stall_cnt   (stall_cnt),
        .flush_cnt   (flush_cnt)
`endif
    );

    typedef struct {
        string nm;
        bit    rst;
        bit    br;
        bit    idv;
        int    rn;
        int    rm;
        bit    urn;
        bit    urm;
        int    rd;
        bit    rw;
        bit    mr;
        int    fa;
        int    fb;
        bit    st;
        bit    fl;
    } vec_t;

    typedef struct {
        string nm;
        int    fa;
        int    fb;
        bit    st;
        bit    fl;
    } exp_t;

    vec_t vecs[$];
    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic add_v(input string nm, input bit rst, input bit br,
                         input bit idv, input int rn, input int rm,
                         input bit urn, input bit urm, input int rd,
                         input bit rw, input bit mr, input int fa,
                         input int fb, input bit st, input bit fl);
        vec_t v;
        v.nm = nm;   v.rst = rst; v.br = br;   v.idv = idv;
        v.rn = rn;   v.rm = rm;   v.urn = urn; v.urm = urm;
        v.rd = rd;   v.rw = rw;   v.mr = mr;
        v.fa = fa;   v.fb = fb;   v.st = st;   v.fl = fl;
        vecs.push_back(v);
    endtask

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    initial begin
        exp_t e;
        //     name         rst br idv rn rm urn urm rd rw mr  fa fb st fl
        add_v("reset",      1, 1, 1,  1, 2, 1, 1,  3, 1, 1,  0, 0, 0, 0);
        add_v("add_x1",     0, 0, 1,  2, 3, 1, 1,  1, 1, 0,  0, 0, 0, 0);
        add_v("ex_fwd",     0, 0, 1,  1, 5, 1, 1,  4, 1, 0,  1, 0, 0, 0);
        add_v("mem_fwd",    0, 0, 1,  1, 4, 1, 1,  6, 1, 0,  2, 1, 0, 0);
        add_v("add_x1a",    0, 0, 1,  2, 3, 1, 1,  1, 1, 0,  0, 0, 0, 0);
        add_v("add_x1b",    0, 0, 1,  6, 9, 1, 1,  1, 1, 0,  2, 0, 0, 0);
        add_v("youngest",   0, 0, 1,  1, 1, 1, 1,  6, 1, 0,  1, 1, 0, 0);
        add_v("xzr_wr",     0, 0, 1,  1, 2, 1, 1, 31, 1, 0,  2, 0, 0, 0);
        add_v("xzr_rd",     0, 0, 1, 31, 5, 1, 1,  4, 1, 0,  0, 0, 0, 0);
        add_v("stur",       0, 0, 1,  0, 7, 1, 1,  3, 0, 0,  0, 0, 0, 0);
        add_v("no_wr",      0, 0, 1,  3, 4, 1, 1,  8, 1, 0,  0, 2, 0, 0);
        add_v("use_bits",   0, 0, 1,  8, 8, 0, 1, 10, 1, 0,  0, 1, 0, 0);
        add_v("ldur",       0, 0, 1,  0,10, 1, 0,  7, 1, 1,  0, 0, 0, 0);
        add_v("lu_stall",   0, 0, 1,  7, 8, 1, 1,  8, 1, 0,  1, 0, 1, 0);
        add_v("lu_fwd",     0, 0, 1,  7, 8, 1, 1,  8, 1, 0,  2, 0, 0, 0);
        add_v("after_lu",   0, 0, 1,  7, 8, 1, 1, 11, 1, 0,  0, 1, 0, 0);
        add_v("branch",     0, 0, 1,  0, 0, 0, 0,  0, 0, 0,  0, 0, 0, 0);
        add_v("ldur2",      0, 0, 1,  0, 0, 1, 0,  7, 1, 1,  0, 0, 0, 0);
        add_v("collide",    0, 1, 1,  7, 9, 1, 1,  8, 1, 0,  1, 0, 0, 1);
        add_v("post_fl",    0, 1, 1,  7,11, 1, 1, 12, 1, 0,  0, 0, 0, 0);
        add_v("fill_ld",    0, 0, 1, 12,12, 1, 1, 13, 1, 1,  1, 1, 0, 0);
        add_v("mid_rst",    1, 1, 1, 13,12, 1, 1, 14, 1, 1,  0, 0, 0, 0);
        add_v("rst_empty",  0, 0, 1, 13,12, 1, 1, 14, 1, 0,  0, 0, 0, 0);
        add_v("branch2",    0, 0, 1,  0, 0, 0, 0,  0, 0, 0,  0, 0, 0, 0);
        add_v("add_x15",    0, 0, 1, 14, 3, 1, 1, 15, 1, 0,  2, 0, 0, 0);
        add_v("flush",      0, 1, 1, 15,14, 1, 1, 16, 1, 0,  1, 0, 0, 1);
        add_v("post_fl2",   0, 0, 1, 15,16, 1, 1, 17, 1, 0,  0, 0, 0, 0);
        add_v("ldur3",      0, 0, 1,  0, 0, 0, 0, 20, 1, 1,  0, 0, 0, 0);
        add_v("lu_rm",      0, 0, 1,  1,20, 1, 1, 21, 1, 0,  0, 1, 1, 0);
        add_v("lu_rm_fwd",  0, 0, 1,  1,20, 1, 1, 21, 1, 0,  0, 2, 0, 0);
        add_v("ldur4",      0, 0, 1,  0, 0, 0, 0, 22, 1, 1,  0, 0, 0, 0);
        add_v("idle_lu",    0, 0, 0, 22, 0, 1, 0,  0, 0, 0,  1, 0, 0, 0);
        add_v("idle_bub",   0, 0, 1, 22,21, 1, 1, 23, 1, 0,  2, 0, 0, 0);

        reset = 1'b1; id_valid = 1'b0; id_rn = '0; id_rm = '0;
        id_use_rn = 1'b0; id_use_rm = 1'b0; id_rd = '0;
        id_regwrite = 1'b0; id_memread = 1'b0; br_taken = 1'b0;
        @(posedge clk);
        #1;

        for (int i = 0; i < vecs.size(); i++) begin
            reset       = vecs[i].rst;
            br_taken    = vecs[i].br;
            id_valid    = vecs[i].idv;
            id_rn       = 5'(vecs[i].rn);
            id_rm       = 5'(vecs[i].rm);
            id_use_rn   = vecs[i].urn;
            id_use_rm   = vecs[i].urm;
            id_rd       = 5'(vecs[i].rd);
            id_regwrite = vecs[i].rw;
            id_memread  = vecs[i].mr;
            e.nm = vecs[i].nm;
            e.fa = vecs[i].fa;
            e.fb = vecs[i].fb;
            e.st = vecs[i].st;
            e.fl = vecs[i].fl;
            exp_q.push_back(e);

            @(negedge clk);
            e = exp_q.pop_front();
            chk({e.nm, ".fwd_a"}, int'(fwd_a), e.fa);
            chk({e.nm, ".fwd_b"}, int'(fwd_b), e.fb);
            chk({e.nm, ".stall"}, int'(stall), int'(e.st));
            chk({e.nm, ".flush"}, int'(flush), int'(e.fl));
`ifdef HAZARD_PERF_EN
            if (vecs[i].nm == "post_fl") begin
                chk("collide.stall_cnt", int'(stall_cnt), 1);
                chk("collide.flush_cnt", int'(flush_cnt), 1);
            end
            if (vecs[i].nm == "mid_rst") begin
                chk("rst.stall_cnt", int'(stall_cnt), 1);
            end
            if (vecs[i].nm == "rst_empty") begin
                chk("cleared.stall_cnt", int'(stall_cnt), 0);
                chk("cleared.flush_cnt", int'(flush_cnt), 0);
            end
`endif
            @(posedge clk);
            #1;
        end

`ifdef HAZARD_PERF_EN
        chk("end.stall_cnt", int'(stall_cnt), 1);
        chk("end.flush_cnt", int'(flush_cnt), 1);
`endif

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
